// File: rtl/ex_unit_pipe_pkg.sv
// Op codes and FSM encodings shared by the execute stage and its multiplier.
package ex_unit_pipe_pkg;
   localparam logic [3:0] EX_ADD   = 4'd0;
   localparam logic [3:0] EX_SUB   = 4'd1;
   localparam logic [3:0] EX_AND   = 4'd2;
   localparam logic [3:0] EX_OR    = 4'd3;
   localparam logic [3:0] EX_XOR   = 4'd4;
   localparam logic [3:0] EX_SLL   = 4'd5;
   localparam logic [3:0] EX_SRL   = 4'd6;
   localparam logic [3:0] EX_ROL   = 4'd7;
   localparam logic [3:0] EX_PASSA = 4'd8;
   localparam logic [3:0] EX_PASSB = 4'd9;
   localparam logic [3:0] EX_SEQ   = 4'd10;
   localparam logic [3:0] EX_SLT   = 4'd11;
   localparam logic [3:0] EX_SLE   = 4'd12;
   localparam logic [3:0] EX_SCO   = 4'd13;
   localparam logic [3:0] EX_MUL   = 4'd14;
   localparam logic [3:0] EX_RSVD  = 4'd15;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_MUL  = 1'b1;
endpackage

// File: rtl/ex_mul_iter.sv
// Iterative shift-add multiplier, low WIDTH bits of a*b; WIDTH cycles after start, done on the last.
// No backpressure: start is ignored while busy; abort/rst return it to idle.
module ex_mul_iter
   import ex_unit_pipe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             abort,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam logic [SHW:0] CNT_FULL = (SHW+1)'(WIDTH);
   localparam logic [SHW:0] CNT_ONE  = (SHW+1)'(1);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] addend;
   logic [SHW:0]     count;

   always_comb begin
      addend = mplier[0] ? mcand : '0;
   end

   assign busy    = (count != '0);
   assign done    = (count == CNT_ONE);
   // Final partial product is folded in combinationally so the caller can register it on done.
   assign product = acc + addend;

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         count  <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start && !busy) begin
         mcand  <= a;
         mplier <= b;
         acc    <= '0;
         count  <= CNT_FULL;
      end else if (busy) begin
         acc    <= acc + addend;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count - CNT_ONE;
      end
   end
endmodule

// File: rtl/ex_unit_pipe.sv
// Registered execute stage: ALU/set/shift/branch add in 1 cycle, MUL in WIDTH+1 cycles.
// Single output slot; in_ready drops while the slot is held, a MUL is running, or on rst/flush.
module ex_unit_pipe
   import ex_unit_pipe_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int SHW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       op,
   input  logic             use_imm,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] br_target,
   output logic             zero,
   output logic             ltz,
   output logic             err
);
   logic             state;
   logic             accept;
   logic             mul_start;
   logic             mul_busy;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;
   logic [WIDTH-1:0] br_pend;

   logic [WIDTH-1:0] opb;
   logic [SHW-1:0]   sh;
   logic [WIDTH:0]   sum_c;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] alu_res;
   logic             alu_err;

   assign in_ready  = ~rst & ~flush & (state == ST_IDLE) & (~out_valid | out_ready);
   assign accept    = in_valid & in_ready;
   assign mul_start = accept & (op == EX_MUL);

   always_comb begin
      opb     = use_imm ? imm : b;
      sh      = opb[SHW-1:0];
      sum_c   = {1'b0, a} + {1'b0, opb};
      sum     = sum_c[WIDTH-1:0];
      diff    = a - opb;
      alu_res = '0;
      alu_err = 1'b0;
      case (op)
         EX_ADD: begin
            alu_res = sum;
            alu_err = (a[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         EX_SUB: begin
            alu_res = diff;
            alu_err = (a[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         EX_AND:   alu_res = a & opb;
         EX_OR:    alu_res = a | opb;
         EX_XOR:   alu_res = a ^ opb;
         EX_SLL:   alu_res = a << sh;
         EX_SRL:   alu_res = a >> sh;
         // A shift of WIDTH yields zero, so rotate by 0 degenerates cleanly to a.
         EX_ROL:   alu_res = (a << sh) | (a >> (WIDTH - int'(sh)));
         EX_PASSA: alu_res = a;
         EX_PASSB: alu_res = opb;
         EX_SEQ:   alu_res = {{(WIDTH-1){1'b0}}, (a == opb)};
         EX_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(opb))};
         EX_SLE:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(opb))};
         EX_SCO:   alu_res = {{(WIDTH-1){1'b0}}, sum_c[WIDTH]};
         EX_MUL:   alu_res = '0;
         default:  alu_err = 1'b1;
      endcase
   end

   ex_mul_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_mul (
      .clk     (clk),
      .rst     (rst),
      .abort   (flush),
      .start   (mul_start),
      .a       (a),
      .b       (opb),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         br_target <= '0;
         br_pend   <= '0;
         zero      <= 1'b0;
         ltz       <= 1'b0;
         err       <= 1'b0;
      end else if (flush) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         err       <= 1'b0;
      end else if (mul_start) begin
         state     <= ST_MUL;
         out_valid <= 1'b0;
         br_pend   <= pc + imm;
      end else if (accept) begin
         out_valid <= 1'b1;
         result    <= alu_res;
         br_target <= pc + imm;
         zero      <= (alu_res == '0);
         ltz       <= alu_res[WIDTH-1];
         err       <= alu_err;
      end else if (state == ST_MUL) begin
         if (mul_done) begin
            state     <= ST_IDLE;
            out_valid <= 1'b1;
            result    <= mul_product;
            br_target <= br_pend;
            zero      <= (mul_product == '0);
            ltz       <= mul_product[WIDTH-1];
            err       <= 1'b0;
         end else if (!mul_busy) begin
            state <= ST_IDLE;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_ex_unit_pipe.sv
// Directed bench for ex_unit_pipe at WIDTH=16 with hand-computed expectations.
module tb_ex_unit_pipe;
   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready, use_imm;
   logic [3:0]  op;
   logic [15:0] a, b, imm, pc;
   logic        out_valid, out_ready, zero, ltz, err;
   logic [15:0] result, br_target;

   int tests = 0;
   int fails = 0;

   ex_unit_pipe #(.WIDTH(16), .SHW(4)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .use_imm(use_imm), .a(a), .b(b), .imm(imm), .pc(pc),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .br_target(br_target),
      .zero(zero), .ltz(ltz), .err(err)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h, expected %h", name, obs, exp);
      end
   endtask

   // Present one op for one accepting edge; afterwards the bench sits in the following cycle.
   task automatic issue(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                        input logic [15:0] iv, input logic ui, input logic [15:0] pv);
      op = o; a = av; b = bv; imm = iv; use_imm = ui; pc = pv; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      logic seen;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      op = '0; a = '0; b = '0; imm = '0; use_imm = 1'b0; pc = '0;
      tick(); tick();
      chk("rst_out_valid", {15'd0, out_valid}, 16'h0000);
      chk("rst_result", result, 16'h0000);
      chk("rst_br_target", br_target, 16'h0000);
      chk("rst_flags", {13'd0, zero, ltz, err}, 16'h0000);
      chk("rst_in_ready", {15'd0, in_ready}, 16'h0000);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", {15'd0, in_ready}, 16'h0001);

      issue(4'd0, 16'h7FFF, 16'h0001, 16'h0000, 1'b0, 16'h0000);
      chk("add_ovf_valid", {15'd0, out_valid}, 16'h0001);
      chk("add_ovf_result", result, 16'h8000);
      chk("add_ovf_flags", {13'd0, zero, ltz, err}, 16'h0003);

      issue(4'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 16'h0000);
      chk("sub_eq_result", result, 16'h0000);
      chk("sub_eq_flags", {13'd0, zero, ltz, err}, 16'h0004);

      issue(4'd1, 16'h8000, 16'h0001, 16'h0000, 1'b0, 16'h0000);
      chk("sub_ovf_result", result, 16'h7FFF);
      chk("sub_ovf_err", {15'd0, err}, 16'h0001);

      issue(4'd11, 16'hFFFF, 16'h0000, 16'h0001, 1'b1, 16'h0000);
      chk("slt_result", result, 16'h0001);

      issue(4'd13, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 16'h0000);
      chk("sco_result", result, 16'h0001);
      chk("sco_err", {15'd0, err}, 16'h0000);

      issue(4'd15, 16'h1234, 16'h5678, 16'h0000, 1'b0, 16'h0000);
      chk("rsvd_result", result, 16'h0000);
      chk("rsvd_err", {15'd0, err}, 16'h0001);

      issue(4'd7, 16'h8001, 16'h0011, 16'h0000, 1'b0, 16'h0000);
      chk("rol_result", result, 16'h0003);
      issue(4'd7, 16'h1234, 16'h0010, 16'h0000, 1'b0, 16'h0000);
      chk("rol0_result", result, 16'h1234);
      issue(4'd6, 16'h8000, 16'h000F, 16'h0000, 1'b0, 16'h0000);
      chk("srl_result", result, 16'h0001);
      issue(4'd5, 16'h0001, 16'h0011, 16'h0000, 1'b0, 16'h0000);
      chk("sll17_result", result, 16'h0002);

      issue(4'd0, 16'h0000, 16'h0000, 16'h0004, 1'b1, 16'hFFFE);
      chk("br_target_wrap", br_target, 16'h0002);
      chk("br_add_result", result, 16'h0004);
      chk("br_add_err", {15'd0, err}, 16'h0000);

      issue(4'd2, 16'hF0F0, 16'h0FF0, 16'h0000, 1'b0, 16'h0000);
      chk("and_result", result, 16'h00F0);
      issue(4'd3, 16'hF000, 16'h000F, 16'h0000, 1'b0, 16'h0000);
      chk("or_result", result, 16'hF00F);
      chk("or_ltz", {15'd0, ltz}, 16'h0001);
      issue(4'd4, 16'hFFFF, 16'h00FF, 16'h0000, 1'b0, 16'h0000);
      chk("xor_result", result, 16'hFF00);
      issue(4'd8, 16'hABCD, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      chk("passa_result", result, 16'hABCD);
      issue(4'd9, 16'h0000, 16'h1111, 16'hFFF8, 1'b1, 16'h0000);
      chk("passb_imm_result", result, 16'hFFF8);
      issue(4'd12, 16'h0005, 16'h0005, 16'h0000, 1'b0, 16'h0000);
      chk("sle_eq_result", result, 16'h0001);
      issue(4'd10, 16'h0003, 16'h0004, 16'h0000, 1'b0, 16'h0000);
      chk("seq_ne_result", result, 16'h0000);
      chk("seq_ne_zero", {15'd0, zero}, 16'h0001);

      // MUL 3 * FFFF: busy for 16 cycles, result at N+17.
      issue(4'd14, 16'h0003, 16'hFFFF, 16'h0002, 1'b0, 16'h0010);
      for (int i = 1; i <= 16; i++) begin
         chk($sformatf("mul_busy_in_ready_c%0d", i), {15'd0, in_ready}, 16'h0000);
         chk($sformatf("mul_busy_out_valid_c%0d", i), {15'd0, out_valid}, 16'h0000);
         tick();
      end
      chk("mul_out_valid", {15'd0, out_valid}, 16'h0001);
      chk("mul_result", result, 16'hFFFD);
      chk("mul_err", {15'd0, err}, 16'h0000);
      chk("mul_br_target", br_target, 16'h0012);

      // Most-negative operand wraps, with a bounded wait for completion.
      issue(4'd14, 16'h8000, 16'h0003, 16'h0000, 1'b0, 16'h0000);
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (out_valid) seen = 1'b1;
         else tick();
      end
      chk("mul_neg_done", {15'd0, seen}, 16'h0001);
      chk("mul_neg_result", result, 16'h8000);
      chk("mul_neg_err", {15'd0, err}, 16'h0000);
      tick();

      // Backpressure: slot held two cycles while a new op waits.
      out_ready = 1'b0;
      issue(4'd0, 16'h0001, 16'h0002, 16'h0000, 1'b0, 16'h0000);
      op = 4'd0; a = 16'h0010; b = 16'h0010; use_imm = 1'b0; in_valid = 1'b1;
      #1;
      chk("bp_in_ready_c0", {15'd0, in_ready}, 16'h0000);
      for (int i = 1; i <= 2; i++) begin
         tick();
         chk($sformatf("bp_hold_result_c%0d", i), result, 16'h0003);
         chk($sformatf("bp_hold_valid_c%0d", i), {15'd0, out_valid}, 16'h0001);
         chk($sformatf("bp_in_ready_c%0d", i), {15'd0, in_ready}, 16'h0000);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", {15'd0, in_ready}, 16'h0001);
      tick();
      in_valid = 1'b0;
      chk("bp_next_result", result, 16'h0020);
      chk("bp_next_valid", {15'd0, out_valid}, 16'h0001);

      // Flush during MUL at N+5.
      issue(4'd14, 16'h0003, 16'h0003, 16'h0000, 1'b0, 16'h0000);
      tick(); tick(); tick(); tick();
      flush = 1'b1;
      #1;
      chk("flush_in_ready_low", {15'd0, in_ready}, 16'h0000);
      tick();
      flush = 1'b0;
      #1;
      chk("flush_in_ready_n6", {15'd0, in_ready}, 16'h0001);
      chk("flush_out_valid_n6", {15'd0, out_valid}, 16'h0000);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      chk("flush_no_mul_output", {15'd0, seen}, 16'h0000);

      // Flush of a held entry clears valid and err.
      out_ready = 1'b0;
      issue(4'd15, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0000);
      chk("held_rsvd_err", {15'd0, err}, 16'h0001);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_held_valid", {15'd0, out_valid}, 16'h0000);
      chk("flush_held_err", {15'd0, err}, 16'h0000);
      out_ready = 1'b1;

      // Reset mid-MUL, preceded by a visible entry so clearing is observable.
      issue(4'd1, 16'h0000, 16'h0001, 16'h0005, 1'b0, 16'h0003);
      issue(4'd14, 16'h0005, 16'h0005, 16'h0000, 1'b0, 16'h0000);
      tick(); tick();
      rst = 1'b1;
      tick();
      chk("rst_mid_valid", {15'd0, out_valid}, 16'h0000);
      chk("rst_mid_result", result, 16'h0000);
      chk("rst_mid_br_target", br_target, 16'h0000);
      chk("rst_mid_flags", {13'd0, zero, ltz, err}, 16'h0000);
      rst = 1'b0;
      #1;
      chk("rst_mid_in_ready", {15'd0, in_ready}, 16'h0001);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid) seen = 1'b1;
         tick();
      end
      chk("rst_mid_no_output", {15'd0, seen}, 16'h0000);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
